// File: rtl/can_tx_mailbox_arbiter_if.sv
// MAC transmit request/outcome handshake between the mailbox arbiter (master)
// and the CAN MAC TX engine (slave).
interface can_tx_mailbox_arbiter_if #(
    parameter int ID_W = 11
);
    logic            tx_valid;
    logic            tx_ready;
    logic [ID_W-1:0] tx_identifier;
    logic [3:0]      tx_dlc;
    logic [63:0]     tx_data;
    logic            tx_done;
    logic            tx_arb_lost;
    logic            tx_error;

    modport master (
        output tx_valid, tx_identifier, tx_dlc, tx_data,
        input  tx_ready, tx_done, tx_arb_lost, tx_error
    );

    modport slave (
        input  tx_valid, tx_identifier, tx_dlc, tx_data,
        output tx_ready, tx_done, tx_arb_lost, tx_error
    );
endinterface

// File: rtl/can_tx_mailbox_arbiter.sv
// Shares one CAN MAC TX path among N_MB mailboxes: lowest pending identifier
// wins, lost arbitration re-queues, bus errors retry up to MAX_RETRY times.
module can_tx_mailbox_arbiter #(
    parameter int N_MB      = 4,
    parameter int ID_W      = 11,
    parameter int MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_MB-1:0]      mb_req,
    input  logic [N_MB-1:0]      mb_abort,
    input  logic [N_MB*ID_W-1:0] mb_id,
    input  logic [N_MB*4-1:0]    mb_dlc,
    input  logic [N_MB*64-1:0]   mb_data,
    output logic [N_MB-1:0]      mb_pending,
    output logic [N_MB-1:0]      mb_done,
    output logic [N_MB-1:0]      mb_fail,
    output logic                 busy,
    can_tx_mailbox_arbiter_if.master tx
);
    localparam int IW = $clog2(N_MB);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

    typedef enum logic [1:0] {IDLE, SELECT, REQUEST, WAIT} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   win_q;
    logic            abort_rec_q, abort_rec_d;
    logic [RW-1:0]   retry_q [N_MB];
    logic [RW-1:0]   retry_d [N_MB];
    logic [N_MB-1:0] pend_d, done_d, fail_d;
    logic [N_MB-1:0] cand;
    logic            sel_any;
    logic [IW-1:0]   sel_idx;
    logic [ID_W-1:0] sel_id;
    logic            inflight, wait_abort;

    assign inflight    = (state_q == REQUEST) || (state_q == WAIT);
    assign busy        = inflight;
    assign tx.tx_valid = (state_q == REQUEST);
    assign wait_abort  = abort_rec_q | mb_abort[win_q];

    // Strict less-than while scanning upward keeps the lower index on ties.
    always_comb begin
        cand    = mb_pending & ~mb_abort;
        sel_any = 1'b0;
        sel_idx = '0;
        sel_id  = '0;
        for (int i = 0; i < N_MB; i++) begin
            if (cand[i] && (!sel_any || mb_id[i*ID_W +: ID_W] < sel_id)) begin
                sel_any = 1'b1;
                sel_idx = IW'(i);
                sel_id  = mb_id[i*ID_W +: ID_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        abort_rec_d = abort_rec_q;
        pend_d      = mb_pending;
        done_d      = '0;
        fail_d      = '0;
        retry_d     = retry_q;

        // Host requests/aborts for every mailbox not currently on the bus.
        for (int i = 0; i < N_MB; i++) begin
            if (!(inflight && win_q == IW'(i))) begin
                if (mb_abort[i]) begin
                    fail_d[i] = mb_pending[i] | mb_req[i];
                    pend_d[i] = 1'b0;
                end else if (mb_req[i] && !mb_pending[i]) begin
                    pend_d[i]  = 1'b1;
                    retry_d[i] = '0;
                end
            end
        end

        case (state_q)
            IDLE: if (|mb_pending) state_d = SELECT;
            SELECT: begin
                abort_rec_d = 1'b0;
                state_d     = sel_any ? REQUEST : IDLE;
            end
            REQUEST: begin
                // An abort coinciding with acceptance is settled by the outcome.
                if (tx.tx_ready) begin
                    state_d     = WAIT;
                    abort_rec_d = mb_abort[win_q];
                end else if (mb_abort[win_q]) begin
                    pend_d[win_q] = 1'b0;
                    fail_d[win_q] = 1'b1;
                    state_d       = IDLE;
                end
            end
            WAIT: begin
                if (mb_abort[win_q]) abort_rec_d = 1'b1;
                if (tx.tx_done) begin
                    pend_d[win_q] = 1'b0;
                    done_d[win_q] = 1'b1;
                    state_d       = IDLE;
                end else if (tx.tx_error) begin
                    state_d = IDLE;
                    if (wait_abort || retry_q[win_q] == RMAX) begin
                        pend_d[win_q]  = 1'b0;
                        fail_d[win_q]  = 1'b1;
                        retry_d[win_q] = '0;
                    end else begin
                        retry_d[win_q] = retry_q[win_q] + RW'(1);
                    end
                end else if (tx.tx_arb_lost) begin
                    state_d = IDLE;
                    if (wait_abort) begin
                        pend_d[win_q] = 1'b0;
                        fail_d[win_q] = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mb_pending       <= '0;
            mb_done          <= '0;
            mb_fail          <= '0;
            abort_rec_q      <= 1'b0;
            retry_q          <= '{default: '0};
            win_q            <= '0;
            tx.tx_identifier <= '0;
            tx.tx_dlc        <= '0;
            tx.tx_data       <= '0;
        end else begin
            mb_pending  <= pend_d;
            mb_done     <= done_d;
            mb_fail     <= fail_d;
            abort_rec_q <= abort_rec_d;
            retry_q     <= retry_d;
            if (state_q == SELECT && sel_any) begin
                win_q            <= sel_idx;
                tx.tx_identifier <= sel_id;
                tx.tx_dlc        <= mb_dlc[sel_idx*4 +: 4];
                tx.tx_data       <= mb_data[sel_idx*64 +: 64];
            end
        end
    end
endmodule

// File: tb/tb_can_tx_mailbox_arbiter.sv
// Directed bench for can_tx_mailbox_arbiter: latency, priority order,
// arbitration loss, error retries, aborts and asynchronous reset.
module tb_can_tx_mailbox_arbiter;
    localparam int N_MB = 4;
    localparam int ID_W = 11;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N_MB-1:0]      mb_req, mb_abort;
    logic [N_MB*ID_W-1:0] mb_id;
    logic [N_MB*4-1:0]    mb_dlc;
    logic [N_MB*64-1:0]   mb_data;
    logic [N_MB-1:0]      mb_pending, mb_done, mb_fail;
    logic                 busy;

    can_tx_mailbox_arbiter_if #(.ID_W(ID_W)) tx_if ();

    can_tx_mailbox_arbiter #(.N_MB(N_MB), .ID_W(ID_W), .MAX_RETRY(3)) dut (
        .clk(clk), .reset(reset),
        .mb_req(mb_req), .mb_abort(mb_abort),
        .mb_id(mb_id), .mb_dlc(mb_dlc), .mb_data(mb_data),
        .mb_pending(mb_pending), .mb_done(mb_done), .mb_fail(mb_fail),
        .busy(busy), .tx(tx_if)
    );

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int fail_cnt = 0;

    always @(posedge clk) begin
        done_cnt <= done_cnt + $countones(mb_done);
        fail_cnt <= fail_cnt + $countones(mb_fail);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mb(input int i, input logic [10:0] id, input logic [3:0] dlc,
                          input logic [63:0] data);
        mb_id[i*ID_W +: ID_W] = id;
        mb_dlc[i*4 +: 4]      = dlc;
        mb_data[i*64 +: 64]   = data;
    endtask

    task automatic req(input logic [N_MB-1:0] m);
        mb_req = m;
        tick();
        mb_req = '0;
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 20; k++) begin
            if (tx_if.tx_valid) break;
            tick();
        end
        chk(tag, tx_if.tx_valid, 1'b1);
    endtask

    // kind: 0 done, 1 arb_lost, 2 error. Ends one tick after the outcome edge.
    task automatic frame(input string tag, input int kind, output logic [10:0] id);
        wait_valid(tag);
        id = tx_if.tx_identifier;
        tick();
        tx_if.tx_done     = (kind == 0);
        tx_if.tx_arb_lost = (kind == 1);
        tx_if.tx_error    = (kind == 2);
        tick();
        tx_if.tx_done     = 1'b0;
        tx_if.tx_arb_lost = 1'b0;
        tx_if.tx_error    = 1'b0;
    endtask

    logic [10:0] id;
    int          base_d, base_f;
    logic [10:0] exp_id [4]  = '{11'h050, 11'h050, 11'h123, 11'h300};
    logic [3:0]  exp_mb [4]  = '{4'b0010, 4'b1000, 4'b0100, 4'b0001};

    initial begin
        reset = 1'b0;
        mb_req = '0; mb_abort = '0; mb_id = '0; mb_dlc = '0; mb_data = '0;
        tx_if.tx_ready = 1'b1; tx_if.tx_done = 1'b0;
        tx_if.tx_arb_lost = 1'b0; tx_if.tx_error = 1'b0;
        tick(); tick();
        chk("rst_pending", mb_pending, 4'b0);
        chk("rst_valid", tx_if.tx_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_id", tx_if.tx_identifier, 11'h0);
        chk("rst_pulses", {mb_done, mb_fail}, 8'h0);
        reset = 1'b1;
        tick();

        // Single frame, 3-cycle request latency
        set_mb(0, 11'h123, 4'd4, 64'hDEADBEEF);
        base_d = done_cnt;
        req(4'b0001);
        chk("t1_pend", mb_pending, 4'b0001);
        chk("t1_v1", tx_if.tx_valid, 1'b0);
        tick();
        chk("t1_v2", tx_if.tx_valid, 1'b0);
        tick();
        chk("t1_v3", tx_if.tx_valid, 1'b1);
        chk("t1_id", tx_if.tx_identifier, 11'h123);
        chk("t1_dlc", tx_if.tx_dlc, 4'd4);
        chk("t1_data", tx_if.tx_data, 64'hDEADBEEF);
        chk("t1_busy", busy, 1'b1);
        tick();
        chk("t1_drop", tx_if.tx_valid, 1'b0);
        tx_if.tx_done = 1'b1;
        tick();
        tx_if.tx_done = 1'b0;
        chk("t1_done", mb_done, 4'b0001);
        chk("t1_pend0", mb_pending, 4'b0);
        tick();
        chk("t1_done_once", done_cnt - base_d, 1);

        // Priority order with a tie on 0x050
        set_mb(0, 11'h300, 4'd1, 64'h0);
        set_mb(1, 11'h050, 4'd2, 64'h1);
        set_mb(2, 11'h123, 4'd3, 64'h2);
        set_mb(3, 11'h050, 4'd4, 64'h3);
        req(4'b1111);
        for (int k = 0; k < 4; k++) begin
            frame($sformatf("t2_v%0d", k), 0, id);
            chk($sformatf("t2_id%0d", k), id, exp_id[k]);
            chk($sformatf("t2_mb%0d", k), mb_done, exp_mb[k]);
        end
        chk("t2_empty", mb_pending, 4'b0);

        // Arbitration loss lets a newly requested higher priority frame in
        set_mb(2, 11'h200, 4'd8, 64'h22);
        set_mb(1, 11'h010, 4'd1, 64'h11);
        req(4'b0100);
        wait_valid("t3_v0");
        chk("t3_id0", tx_if.tx_identifier, 11'h200);
        tick();
        req(4'b0010);
        tx_if.tx_arb_lost = 1'b1;
        tick();
        tx_if.tx_arb_lost = 1'b0;
        chk("t3_pend", mb_pending, 4'b0110);
        chk("t3_retry", dut.retry_q[2], 2'd0);
        frame("t3_v1", 0, id);
        chk("t3_id1", id, 11'h010);
        chk("t3_done1", mb_done, 4'b0010);
        frame("t3_v2", 0, id);
        chk("t3_id2", id, 11'h200);
        chk("t3_done2", mb_done, 4'b0100);

        // Error retries: 4 attempts, fail on the 4th error
        set_mb(0, 11'h0AA, 4'd2, 64'hAA);
        req(4'b0001);
        for (int k = 0; k < 4; k++) begin
            frame($sformatf("t4_v%0d", k), 2, id);
            chk($sformatf("t4_fail%0d", k), mb_fail, (k == 3) ? 4'b0001 : 4'b0000);
            chk($sformatf("t4_pend%0d", k), mb_pending, (k == 3) ? 4'b0000 : 4'b0001);
        end
        for (int k = 0; k < 5; k++) begin
            chk("t4_no_more", tx_if.tx_valid, 1'b0);
            tick();
        end

        // Abort during REQUEST while the MAC stalls
        tx_if.tx_ready = 1'b0;
        set_mb(3, 11'h077, 4'd1, 64'h77);
        req(4'b1000);
        wait_valid("t5_v");
        mb_abort = 4'b1000;
        tick();
        mb_abort = '0;
        chk("t5_valid", tx_if.tx_valid, 1'b0);
        chk("t5_fail", mb_fail, 4'b1000);
        chk("t5_pend", mb_pending, 4'b0);
        chk("t5_busy", busy, 1'b0);
        tx_if.tx_ready = 1'b1;

        // Request and abort in the same cycle: abort wins
        mb_req = 4'b0100; mb_abort = 4'b0100;
        tick();
        mb_req = '0; mb_abort = '0;
        chk("t6_pend", mb_pending, 4'b0);
        tick(); tick(); tick();
        chk("t6_valid", tx_if.tx_valid, 1'b0);

        // Abort in WAIT, then tx_done: only mb_done
        set_mb(1, 11'h042, 4'd3, 64'h42);
        req(4'b0010);
        wait_valid("t7_v");
        tick();
        base_f = fail_cnt;
        mb_abort = 4'b0010;
        tick();
        mb_abort = '0;
        chk("t7_nofail", mb_fail, 4'b0);
        chk("t7_busy", busy, 1'b1);
        tx_if.tx_done = 1'b1;
        tick();
        tx_if.tx_done = 1'b0;
        chk("t7_done", mb_done, 4'b0010);
        chk("t7_fail", mb_fail, 4'b0);
        chk("t7_pend", mb_pending, 4'b0);
        tick();
        chk("t7_failcnt", fail_cnt - base_f, 0);

        // Asynchronous reset in WAIT with three mailboxes pending
        set_mb(0, 11'h100, 4'd1, 64'h1);
        set_mb(1, 11'h101, 4'd1, 64'h2);
        set_mb(2, 11'h102, 4'd1, 64'h3);
        req(4'b0111);
        wait_valid("t8_v");
        tick();
        chk("t8_busy", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("t8_pend", mb_pending, 4'b0);
        chk("t8_busy0", busy, 1'b0);
        chk("t8_valid", tx_if.tx_valid, 1'b0);
        chk("t8_id", tx_if.tx_identifier, 11'h0);
        tick(); tick();
        reset = 1'b1;
        base_d = done_cnt;
        base_f = fail_cnt;
        for (int k = 0; k < 5; k++) tick();
        chk("t8_nopulse", (done_cnt - base_d) + (fail_cnt - base_f), 0);
        chk("t8_idle", {busy, mb_pending}, 5'b0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
